// File: rtl/pe_sched_pkg.sv
// rtl/pe_sched_pkg.sv - shared types for the PE array sequencer
//
// Purpose: wire-connection codes, sequencer FSM states and a counter width
// helper shared by pe_sched_ctrl and pe_sched_skew.
// Ports: none (package).

package pe_sched_pkg;

  // Per-row operand routing code driven into each PE row.
  typedef enum logic [1:0] {
    WC_LOAD  = 2'd0,  // a = v_bus,    b = h_bus
    WC_ACC   = 2'd1,  // a = feedback, b = h_bus
    WC_SHIFT = 2'd2,  // a = top,      b = h_bus
    WC_FMT   = 2'd3   // zero operands, format result
  } wire_code_t;

  // Rows sit in format mode whenever no pass is running.
  localparam wire_code_t WC_IDLE = WC_FMT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ACC   = 3'd2,
    ST_FMT   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_TAIL  = 3'd5,
    ST_DONE  = 3'd6
  } sched_state_t;

  // Bits needed to hold max_val; at least one bit so a zero-length
  // counter still has a legal declaration.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/pe_sched_skew.sv
// rtl/pe_sched_skew.sv - per-row skew delay line for code and feed enable
//
// Purpose: NUM_ROWS-stage shift register carrying {code, feed_en}. Stage r
// is row r's value, so row r sees the input stream r+1 cycles later and
// row 0 is simply the registered input.
// Ports:
//   clk      in   clock
//   flush_i  in   synchronous flush, all stages to idle code / feed 0
//   code_i   in   next row-0 code
//   feed_i   in   next row-0 feed enable
//   code_o   out  per-row code, row r at [2r+1:2r]
//   feed_o   out  per-row feed enable

module pe_sched_skew
  import pe_sched_pkg::*;
#(
  parameter int NUM_ROWS = 4
) (
  input  logic                  clk,
  input  logic                  flush_i,
  input  wire_code_t            code_i,
  input  logic                  feed_i,
  output logic [2*NUM_ROWS-1:0] code_o,
  output logic [NUM_ROWS-1:0]   feed_o
);

  wire_code_t code_q [NUM_ROWS];
  logic       feed_q [NUM_ROWS];

  always_ff @(posedge clk) begin
    if (flush_i) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        code_q[i] <= WC_IDLE;
        feed_q[i] <= 1'b0;
      end
    end else begin
      code_q[0] <= code_i;
      feed_q[0] <= feed_i;
      for (int i = 1; i < NUM_ROWS; i++) begin
        code_q[i] <= code_q[i-1];
        feed_q[i] <= feed_q[i-1];
      end
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_tap
    assign code_o[2*r +: 2] = code_q[r];
    assign feed_o[r]        = feed_q[r];
  end

endmodule

// File: rtl/pe_sched_ctrl.sv
// rtl/pe_sched_ctrl.sv - matrix-multiply pass sequencer for a PE tile column
//
// Purpose: per start pulse runs LOAD, ACC (len cycles), FMT, DRAIN
// (NUM_ROWS cycles), TAIL, DONE and drives every row's wire-connection code,
// operand feed enable and the bottom-row output-valid strobe.
// Macro PE_SCHED_SKEW_EN: when defined, row r receives the row-0 stream
// r cycles later (pe_sched_skew); otherwise all rows share row 0's stream.
// Ports:
//   clk                in   clock
//   rst_n              in   synchronous active-low reset, aborts a pass
//   start_i            in   pass request, sampled while not busy
//   len_i              in   accumulate cycle count, latched on accept
//   busy_o             out  pass in progress
//   done_o             out  one-cycle pass-complete pulse
//   wire_connection_o  out  per-row code, row r at [2r+1:2r]
//   feed_en_o          out  per-row operand feed enable
//   out_valid_o        out  bottom-row result data valid

module pe_sched_ctrl
  import pe_sched_pkg::*;
#(
  parameter int NUM_ROWS  = 4,
  parameter int WIDTH_LEN = 8,
  parameter int OUT_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [WIDTH_LEN-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2*NUM_ROWS-1:0] wire_connection_o,
  output logic [NUM_ROWS-1:0]   feed_en_o,
  output logic                  out_valid_o
);

  // TAIL must cover the time for the last SHIFT code to reach the bottom
  // row plus the PE output latency.
`ifdef PE_SCHED_SKEW_EN
  localparam int TAIL_CYC = NUM_ROWS - 1 + OUT_LAT;
`else
  localparam int TAIL_CYC = OUT_LAT;
`endif
  localparam int DRAIN_W = $clog2(NUM_ROWS + 1);
  localparam int TAIL_W  = cnt_width(TAIL_CYC);

  sched_state_t         state_q, state_d;
  logic [WIDTH_LEN-1:0] len_q, len_d;
  logic [WIDTH_LEN-1:0] acc_cnt_q, acc_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [TAIL_W-1:0]    tail_cnt_q, tail_cnt_d;

  // Row-0 values for the next cycle, decoded from state_d so that the
  // row registers (and hence all outputs) line up with state_q.
  wire_code_t code_nxt;
  logic       feed_nxt;
  logic       busy_nxt;
  logic       done_nxt;
  logic       busy_q;
  logic       done_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      drain_cnt_q <= '0;
      tail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_cnt_d   = acc_cnt_q;
    drain_cnt_d = drain_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A zero length skips ACC entirely, so the ACC counter never wraps.
        if (len_q == '0) begin
          state_d = ST_FMT;
        end else begin
          acc_cnt_d = len_q;
          state_d   = ST_ACC;
        end
      end
      ST_ACC: begin
        if (acc_cnt_q == WIDTH_LEN'(1)) begin
          state_d = ST_FMT;
        end else begin
          acc_cnt_d = acc_cnt_q - WIDTH_LEN'(1);
        end
      end
      ST_FMT: begin
        drain_cnt_d = DRAIN_W'(NUM_ROWS);
        state_d     = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(1)) begin
          if (TAIL_CYC == 0) begin
            state_d = ST_DONE;
          end else begin
            tail_cnt_d = TAIL_W'(TAIL_CYC);
            state_d    = ST_TAIL;
          end
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end
      ST_TAIL: begin
        if (tail_cnt_q == TAIL_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          tail_cnt_d = tail_cnt_q - TAIL_W'(1);
        end
      end
      ST_DONE: begin
        // Not busy here, so a new request is taken without an IDLE gap.
        if (start_i) begin
          len_d   = len_i;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    code_nxt = WC_IDLE;
    feed_nxt = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_d)
      ST_LOAD: begin
        code_nxt = WC_LOAD;
        feed_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      ST_ACC: begin
        code_nxt = WC_ACC;
        feed_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      ST_FMT: begin
        code_nxt = WC_FMT;
        busy_nxt = 1'b1;
      end
      ST_DRAIN: begin
        code_nxt = WC_SHIFT;
        busy_nxt = 1'b1;
      end
      ST_TAIL: begin
        busy_nxt = 1'b1;
      end
      ST_DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        code_nxt = WC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

`ifdef PE_SCHED_SKEW_EN
  pe_sched_skew #(
    .NUM_ROWS (NUM_ROWS)
  ) u_skew (
    .clk     (clk),
    .flush_i (!rst_n),
    .code_i  (code_nxt),
    .feed_i  (feed_nxt),
    .code_o  (wire_connection_o),
    .feed_o  (feed_en_o)
  );
`else
  logic [1:0] row_code_q;
  logic       row_feed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_code_q <= WC_IDLE;
      row_feed_q <= 1'b0;
    end else begin
      row_code_q <= code_nxt;
      row_feed_q <= feed_nxt;
    end
  end

  assign wire_connection_o = {NUM_ROWS{row_code_q}};
  assign feed_en_o         = {NUM_ROWS{row_feed_q}};
`endif

  // Bottom row is already registered; OUT_LAT more stages model the PE's
  // own path from seeing SHIFT to presenting bot_data.
  logic [1:0] bottom_code;
  logic       bottom_shift;

  assign bottom_code  = wire_connection_o[2*NUM_ROWS-1 -: 2];
  assign bottom_shift = (bottom_code == WC_SHIFT);

  if (OUT_LAT == 0) begin : g_ov_direct
    assign out_valid_o = bottom_shift;
  end else begin : g_ov_pipe
    logic [OUT_LAT-1:0] ov_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ov_q <= '0;
      end else begin
        ov_q[0] <= bottom_shift;
        for (int i = 1; i < OUT_LAT; i++) begin
          ov_q[i] <= ov_q[i-1];
        end
      end
    end

    assign out_valid_o = ov_q[OUT_LAT-1];
  end

endmodule

// File: tb/tb_pe_sched_ctrl.sv
// tb/tb_pe_sched_ctrl.sv - self-checking bench for pe_sched_ctrl

module tb_pe_sched_ctrl;

  localparam int N  = 4;
  localparam int WL = 8;
  localparam int OL = 2;
`ifdef PE_SCHED_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start_i;
  logic [WL-1:0]   len_i;
  logic            busy_o;
  logic            done_o;
  logic [2*N-1:0]  wire_connection_o;
  logic [N-1:0]    feed_en_o;
  logic            out_valid_o;

  int errors;
  int checks;

  pe_sched_ctrl #(
    .NUM_ROWS  (N),
    .WIDTH_LEN (WL),
    .OUT_LAT   (OL)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_i           (start_i),
    .len_i             (len_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .wire_connection_o (wire_connection_o),
    .feed_en_o         (feed_en_o),
    .out_valid_o       (out_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row-0 code at cycle c of a pass of length L (start sampled at cycle 0).
  function automatic logic [1:0] row0_code(input int c, input int L);
    if (c == 1) return 2'd0;
    if (c >= 2 && c <= L + 1) return 2'd1;
    if (c == L + 2) return 2'd3;
    if (c >= L + 3 && c <= L + 2 + N) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic row0_feed(input int c, input int L);
    return (c >= 1 && c <= L + 1);
  endfunction

  function automatic int dly(input int r);
    return SKEW ? r : 0;
  endfunction

  function automatic int done_cyc(input int L);
    return SKEW ? (L + 2*N + 2 + OL) : (L + N + 3 + OL);
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    start_i = 1'b0;
    len_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (wire_connection_o !== {N{2'd3}}) begin
        errors++;
        $display("FAIL reset_codes cycle %0d: got %h want %h", c, wire_connection_o, {N{2'd3}});
      end
      checks++;
      if (feed_en_o !== '0) begin
        errors++;
        $display("FAIL reset_feed cycle %0d: got %b want 0", c, feed_en_o);
      end
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags cycle %0d: busy %b done %b ov %b want 0 0 0", c, busy_o, done_o, out_valid_o);
      end
    end
  endtask

  // Full pass with every output compared each cycle through the first
  // idle cycle after done.
  task automatic test_pass(input int L);
    logic [2*N-1:0] exp_wc;
    logic [N-1:0]   exp_fe;
    logic           exp_ov;
    int             d;
    int             ov_cnt;
    d      = done_cyc(L);
    ov_cnt = 0;
    start_i = 1'b1;
    len_i   = WL'(L);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    len_i   = WL'(L + 7);
    for (int c = 1; c <= d + 1; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      for (int r = 0; r < N; r++) begin
        int cc;
        cc = c - dly(r);
        exp_wc[2*r +: 2] = (cc >= 1) ? row0_code(cc, L) : 2'd3;
        exp_fe[r]        = (cc >= 1) ? row0_feed(cc, L) : 1'b0;
      end
      begin
        int co;
        co = c - OL - dly(N - 1);
        exp_ov = (co >= 1) && (row0_code(co, L) == 2'd2);
      end
      if (out_valid_o === 1'b1) ov_cnt++;
      checks++;
      if (wire_connection_o !== exp_wc) begin
        errors++;
        $display("FAIL pass_len%0d_codes cycle %0d: got %h want %h", L, c, wire_connection_o, exp_wc);
      end
      checks++;
      if (feed_en_o !== exp_fe) begin
        errors++;
        $display("FAIL pass_len%0d_feed cycle %0d: got %b want %b", L, c, feed_en_o, exp_fe);
      end
      checks++;
      if (out_valid_o !== exp_ov) begin
        errors++;
        $display("FAIL pass_len%0d_out_valid cycle %0d: got %b want %b", L, c, out_valid_o, exp_ov);
      end
      checks++;
      if (busy_o !== (c < d)) begin
        errors++;
        $display("FAIL pass_len%0d_busy cycle %0d: got %b want %b", L, c, busy_o, (c < d));
      end
      checks++;
      if (done_o !== (c == d)) begin
        errors++;
        $display("FAIL pass_len%0d_done cycle %0d: got %b want %b", L, c, done_o, (c == d));
      end
    end
    checks++;
    if (ov_cnt != N) begin
      errors++;
      $display("FAIL pass_len%0d_out_valid_count: got %0d want %0d", L, ov_cnt, N);
    end
  endtask

  // start_i held high with len_i churning: first pass uses the first len,
  // and the start seen in the DONE cycle launches a second pass.
  task automatic test_held_start();
    int d;
    int d2;
    d  = done_cyc(3);
    d2 = done_cyc(1);
    start_i = 1'b1;
    len_i   = WL'(3);
    @(posedge clk);
    for (int c = 1; c <= d; c++) begin
      if (c > 1) @(posedge clk);
      #1;
      len_i = (c == d) ? WL'(1) : WL'((c * 7 + 5) % 13 + 4);
      checks++;
      if (wire_connection_o[1:0] !== row0_code(c, 3)) begin
        errors++;
        $display("FAIL held_row0 cycle %0d: got %0d want %0d", c, wire_connection_o[1:0], row0_code(c, 3));
      end
      checks++;
      if (busy_o !== (c < d) || done_o !== (c == d)) begin
        errors++;
        $display("FAIL held_flags cycle %0d: busy %b done %b want %b %b", c, busy_o, done_o, (c < d), (c == d));
      end
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    checks++;
    if (wire_connection_o[1:0] !== 2'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL held_second_start cycle %0d: code %0d busy %b want 0 1", d + 1, wire_connection_o[1:0], busy_o);
    end
    for (int k = 2; k <= d2 + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        checks++;
        if (wire_connection_o[1:0] !== 2'd1) begin
          errors++;
          $display("FAIL held_second_len cycle %0d: code %0d want 1", d + k, wire_connection_o[1:0]);
        end
        @(posedge clk);
        #1;
        k++;
        checks++;
        if (wire_connection_o[1:0] !== 2'd3) begin
          errors++;
          $display("FAIL held_second_fmt cycle %0d: code %0d want 3", d + k, wire_connection_o[1:0]);
        end
      end
      checks++;
      if (done_o !== (k == d2)) begin
        errors++;
        $display("FAIL held_second_done cycle %0d: got %b want %b", d + k, done_o, (k == d2));
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    int saw_done;
    saw_done = 0;
    start_i = 1'b1;
    len_i   = WL'(5);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (wire_connection_o !== {N{2'd3}} || feed_en_o !== '0) begin
      errors++;
      $display("FAIL abort_rows: codes %h feed %b want %h 0", wire_connection_o, feed_en_o, {N{2'd3}});
    end
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: busy %b done %b ov %b want 0 0 0", busy_o, done_o, out_valid_o);
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done_o !== 1'b0 || busy_o !== 1'b0) saw_done++;
    end
    checks++;
    if (saw_done != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", saw_done);
    end
    test_pass(2);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    start_i = 1'b0;
    len_i   = '0;
    test_reset();
    test_pass(3);
    test_pass(0);
    test_held_start();
    test_reset_mid_pass();
    test_pass(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
